// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: LED brightness sequencer.
// Takes a target duty code over a valid/ready handshake and ramps the duty
// code one step at a time toward it. Each step waits a programmable number of
// PWM frames. The duty output changes only at frame boundaries, so the PWM
// generator never sees a change in the middle of a period.
module pwm_fade_ctrl #(
  parameter int FRAME_BITS = 3,
  parameter int LEVEL_W    = 2,
  parameter int STEP_W     = 8
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LEVEL_W-1:0] req_level,
  input  logic [STEP_W-1:0]  req_step_frames,
  input  logic               abort,
  input  logic               blank,
  output logic [LEVEL_W-1:0] level_out,
  output logic [LEVEL_W-1:0] cur_level,
  output logic               frame_tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_e;

  state_e              state_q,     state_d;
  logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [LEVEL_W-1:0]  cur_level_q, cur_level_d;
  logic [LEVEL_W-1:0]  target_q,    target_d;
  logic [LEVEL_W-1:0]  level_out_q, level_out_d;
  logic [STEP_W-1:0]   dwell_q,     dwell_d;
  logic [STEP_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic                done_q,      done_d;

  // The frame counter always runs. Its last count marks the frame boundary.
  assign frame_tick = &frame_cnt_q;
  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q == S_RAMP);
  assign done       = done_q;
  assign cur_level  = cur_level_q;
  assign level_out  = level_out_q;

  // Next-state logic: request accept, dwell counting, stepping, abort and duty update.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. Paths that do not
    // assign a signal then keep its value, and the tool infers no latch.
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q + FRAME_BITS'(1);
    cur_level_d = cur_level_q;
    target_d    = target_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    level_out_d = level_out_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort has no effect while idle. A request that arrives with it is still accepted.
        if (req_valid) begin
          target_d    = req_level;
          dwell_d     = (req_step_frames == '0) ? STEP_W'(1) : req_step_frames;
          dwell_cnt_d = '0;
          if (req_level == cur_level_q) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RAMP;
          end
        end
      end

      S_RAMP: begin
        if (abort) begin
          // Stop where we are. The target follows the current level, so the state stays consistent.
          state_d     = S_IDLE;
          target_d    = cur_level_q;
          dwell_cnt_d = '0;
        end else if (frame_tick) begin
          if (dwell_cnt_q >= dwell_q - STEP_W'(1)) begin
            dwell_cnt_d = '0;
            // Each step moves one code toward the target. The comparisons keep
            // the level from passing the target, so it cannot wrap past the range ends.
            if (cur_level_q < target_q) begin
              cur_level_d = cur_level_q + LEVEL_W'(1);
            end else if (cur_level_q > target_q) begin
              cur_level_d = cur_level_q - LEVEL_W'(1);
            end
            if (cur_level_d == target_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + STEP_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The duty output loads only at the frame boundary. It includes any step taken on the same edge.
    if (frame_tick) begin
      level_out_d = blank ? '0 : cur_level_d;
    end
  end

  // State registers. An asynchronous reset returns everything to dark/idle at once.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      cur_level_q <= '0;
      target_q    <= '0;
      level_out_q <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments. Every register samples its _d value
      // from before the edge, whatever the statement order.
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      cur_level_q <= cur_level_d;
      target_q    <= target_d;
      level_out_q <= level_out_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Testbench for pwm_fade_ctrl. A table of chained requests with expected
// outputs at given cycles after each accept, plus hand-written sequences for
// blank, abort, reset during a ramp, and a held request.
module tb_pwm_fade_ctrl;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_level;
  logic [7:0] req_step_frames;
  logic       abort;
  logic       blank;
  logic [1:0] level_out;
  logic [1:0] cur_level;
  logic       frame_tick;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 aclk = ~aclk;

  pwm_fade_ctrl #(.FRAME_BITS(3), .LEVEL_W(2), .STEP_W(8)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_level       (req_level),
    .req_step_frames (req_step_frames),
    .abort           (abort),
    .blank           (blank),
    .level_out       (level_out),
    .cur_level       (cur_level),
    .frame_tick      (frame_tick),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    logic [1:0] level;
    logic [7:0] step;
  } req_t;

  typedef struct {
    int         req;
    int         cyc;
    logic [1:0] lo;
    logic [1:0] cur;
    logic       busy;
    logic       done;
    logic       ready;
    logic       tick;
  } vec_t;

  req_t reqs[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
    cyc++;
  endtask

  task automatic advance(input int n);
    while (cyc < n) tick();
  endtask

  task automatic expect_out(input string tag, input logic [1:0] lo, input logic [1:0] cur,
                            input logic b, input logic d, input logic r);
    check({tag, ".level_out"}, 32'(level_out), 32'(lo));
    check({tag, ".cur_level"}, 32'(cur_level), 32'(cur));
    check({tag, ".busy"},      32'(busy),      32'(b));
    check({tag, ".done"},      32'(done),      32'(d));
    check({tag, ".req_ready"}, 32'(req_ready), 32'(r));
  endtask

  task automatic do_reset();
    req_valid = 1'b0; req_level = '0; req_step_frames = '0; abort = 1'b0; blank = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    cyc = 0;
  endtask

  // Leaves the bench at the negedge of the cycle where frame_cnt == k.
  task automatic align(input int k);
    int n = 0;
    while (!frame_tick && n < 16) begin
      tick();
      n++;
    end
    check("align.frame_tick_seen", 32'(frame_tick), 32'd1);
    repeat (k + 1) tick();
  endtask

  task automatic accept(input logic [1:0] lvl, input logic [7:0] stp);
    req_valid = 1'b1; req_level = lvl; req_step_frames = stp;
    cyc = 0;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    // Chained requests. Each one is accepted at the negedge that follows the previous request's last check.
    reqs.push_back('{level: 2'd3, step: 8'd1});   // accept at frame_cnt=2
    reqs.push_back('{level: 2'd0, step: 8'd4});   // accept at frame_cnt=1
    reqs.push_back('{level: 2'd0, step: 8'd5});   // equal level, accept at frame_cnt=1
    //                 req cyc lo cur busy done ready tick
    vecs.push_back('{0,  1, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0,  5, 0, 0, 1, 0, 0, 1});
    vecs.push_back('{0,  6, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{0, 13, 1, 1, 1, 0, 0, 1});
    vecs.push_back('{0, 14, 2, 2, 1, 0, 0, 0});
    vecs.push_back('{0, 21, 2, 2, 1, 0, 0, 1});
    vecs.push_back('{0, 22, 3, 3, 0, 1, 1, 0});
    vecs.push_back('{0, 23, 3, 3, 0, 0, 1, 0});
    vecs.push_back('{1,  1, 3, 3, 1, 0, 0, 0});
    vecs.push_back('{1, 30, 3, 3, 1, 0, 0, 1});
    vecs.push_back('{1, 31, 2, 2, 1, 0, 0, 0});
    vecs.push_back('{1, 62, 2, 2, 1, 0, 0, 1});
    vecs.push_back('{1, 63, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{1, 94, 1, 1, 1, 0, 0, 1});
    vecs.push_back('{1, 95, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{1, 96, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{2,  1, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{2,  2, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{2,  5, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{2,  6, 0, 0, 0, 0, 1, 1});

    // Reset state
    do_reset();
    expect_out("reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("reset.frame_tick", 32'(frame_tick), 32'd0);

    // Table-driven chained requests
    align(2);
    for (int r = 0; r < reqs.size(); r++) begin
      accept(reqs[r].level, reqs[r].step);
      for (int i = 0; i < vecs.size(); i++) begin
        if (vecs[i].req == r) begin
          advance(vecs[i].cyc);
          expect_out($sformatf("tbl%0d.c%0d", r, vecs[i].cyc), vecs[i].lo, vecs[i].cur,
                     vecs[i].busy, vecs[i].done, vecs[i].ready);
          check($sformatf("tbl%0d.c%0d.frame_tick", r, vecs[i].cyc), 32'(frame_tick),
                32'(vecs[i].tick));
        end
      end
    end

    // Blank mid-ramp 0->3 with step=2: three boundaries blanked, stepping continues
    do_reset();
    align(0);
    accept(2'd3, 8'd2);
    advance(16); expect_out("blank.c16", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    advance(17); blank = 1'b1;
    advance(24); expect_out("blank.c24", 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    advance(32); expect_out("blank.c32", 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
    advance(40); expect_out("blank.c40", 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
    advance(41); blank = 1'b0;
    advance(47); expect_out("blank.c47", 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
    advance(48); expect_out("blank.c48", 2'd3, 2'd3, 1'b0, 1'b1, 1'b1);

    // Abort on the step tick at cur_level=1 (target 3)
    do_reset();
    align(0);
    accept(2'd3, 8'd1);
    advance(8);  expect_out("abort.c8", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    advance(15);
    check("abort.tick_on_abort", 32'(frame_tick), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_out("abort.c16", 2'd1, 2'd1, 1'b0, 1'b0, 1'b1);
    advance(17); expect_out("abort.c17", 2'd1, 2'd1, 1'b0, 1'b0, 1'b1);
    advance(24); expect_out("abort.c24", 2'd1, 2'd1, 1'b0, 1'b0, 1'b1);
    // abort in IDLE together with a request: the accept proceeds, and step=0 acts as 1
    abort = 1'b1;
    accept(2'd2, 8'd0);
    abort = 1'b0;
    expect_out("idle_abort.c1", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    advance(8);  expect_out("idle_abort.c8", 2'd2, 2'd2, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset during a ramp
    do_reset();
    align(0);
    accept(2'd3, 8'd1);
    advance(12); expect_out("arst.pre", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    #2 aresetn = 1'b0;
    #1 expect_out("arst.during", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("arst.frame_tick", 32'(frame_tick), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Request held valid across a ramp: accepted only when req_ready returns
    do_reset();
    align(0);
    req_valid = 1'b1; req_level = 2'd3; req_step_frames = 8'd1;
    cyc = 0;
    tick();
    req_level = 2'd2;
    advance(10); expect_out("hold.c10", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    advance(24); expect_out("hold.c24", 2'd3, 2'd3, 1'b0, 1'b1, 1'b1);
    tick();
    req_valid = 1'b0;
    expect_out("hold.c25", 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    advance(31); expect_out("hold.c31", 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    advance(32); expect_out("hold.c32", 2'd2, 2'd2, 1'b0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
